pdm_modulator: RTL and testbench
================================

# pdm_modulator

First-order multi-bit pulse-density modulator (sigma-delta requantizer). It converts a wide unsigned PCM sample into a narrow unsigned DAC code every clock cycle. The long-term average of the output, in output LSBs, equals sample / 2^(INPUT_WIDTH−OUTPUT_WIDTH). It sits between the audio/sample datapath and a low-resolution DAC or pin driver. The downstream analog filter recovers the averaged level.

## Interface
Parameters:
- INPUT_WIDTH, default 5: width of the `sample` input, unsigned.
- OUTPUT_WIDTH, default 2: width of `dac_out`, unsigned. Legal range is 1 ≤ OUTPUT_WIDTH < INPUT_WIDTH.
- Derived value L = INPUT_WIDTH − OUTPUT_WIDTH: the number of fractional (residue) bits.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: reset is synchronous and active-low.
- sample, input, INPUT_WIDTH: unsigned input level. It is sampled on every rising edge. There is no valid/ready handshake.
- dac_out, output, OUTPUT_WIDTH: registered unsigned output code.

## Operation
- Internal state: `err`, an L-bit unsigned residue register.
- Each rising edge with reset high:
  - sum = sample + err, computed at INPUT_WIDTH+1 bits, zero-extended, with no wrap.
  - Normal case, sum < 2^INPUT_WIDTH:
    - dac_out ← sum[INPUT_WIDTH−1:L].
    - err ← sum[L−1:0].
  - Overflow case, sum ≥ 2^INPUT_WIDTH:
    - dac_out ← all ones (saturate).
    - err ← 2^L−1 (clamp).
- Rising edge with reset low:
  - dac_out ← 0 and err ← 0.
  - `sample` is ignored.
- Mean output over any 2^L-cycle window with constant sample and no saturation is exactly sample / 2^L.
- For a constant sample, the output pattern is periodic with a period that divides 2^L. The output only takes the two adjacent codes floor(sample/2^L) and floor(sample/2^L)+1.
- Full-scale sample (all ones) produces constant dac_out = all ones after the first non-reset edge.
- Sample = 0 produces dac_out = 0 forever, because err < 2^L is always true. The residue is held, not cleared.
- A sample change takes effect at the next edge. Err is not reset on a sample change.

## Timing
- Latency: dac_out at edge n is a function of sample at edge n and err from edge n−1. That is one register stage from sample to pin.
- No combinational path from inputs to dac_out.
- Reset:
  - dac_out = 0 and err = 0 from the first edge with reset low, held while reset stays low.
  - The first computed output appears on the first edge with reset high.
- Reset asserted mid-stream discards the residue. After release, the sequence restarts exactly as from power-up.
- No X propagation: dac_out and err must be defined after the first reset edge.

## Test plan
All scenarios use INPUT_WIDTH=5 and OUTPUT_WIDTH=2, so L=3.
1. **Reset:** reset low for 2 edges with sample=1 -> dac_out=00 at both edges. Internal err=0.
2. **Small level:** release reset with sample=1 -> dac_out=00 on edges 1–7 after release and 01 on edge 8. The pattern repeats with period 8.
3. **Mid level:** from err=0 apply sample=15 -> dac_out sequence is 01,10,10,10,10,10,10,10, repeating. Mean is 15/8, and the code 10 appears by the second edge.
4. **Full scale / saturation:** sample=31 -> dac_out=11 on every edge. The sum 38 is clamped to 11 and err held at 7. The output never wraps to 00.
5. **Zero level:** sample=0 after scenario 2 was interrupted at err=5 -> dac_out=00 on every edge. Err stays 5, so when sample=1 is then applied, the next 01 occurs on the 3rd edge.
6. **Reset mid-operation:** pull reset low for 1 edge while err≠0 -> dac_out=00 that edge. After release with sample=1, the first 01 appears exactly on the 8th edge.

Source files
------------

// File: rtl/pdm_modulator_if.sv
// Sample/DAC-code bundle for the PDM modulator, plus a read-only view of the residue.
interface pdm_modulator_if #(
    parameter int INPUT_WIDTH  = 5,
    parameter int OUTPUT_WIDTH = 2
);
    logic [INPUT_WIDTH-1:0]              sample;
    logic [OUTPUT_WIDTH-1:0]             dac_out;
    logic [INPUT_WIDTH-OUTPUT_WIDTH-1:0] err_dbg;

    // There is no valid/ready: sample is consumed on every rising edge and
    // dac_out is a new registered code on every rising edge.
    modport master (output sample, input dac_out, input err_dbg);
    modport slave  (input sample, output dac_out, output err_dbg);
endinterface

// File: rtl/pdm_modulator.sv
// First-order multi-bit sigma-delta requantizer: wide unsigned PCM in, narrow
// DAC code out, with the dropped fraction carried forward in a residue register.
module pdm_modulator #(
    parameter int INPUT_WIDTH  = 5,
    parameter int OUTPUT_WIDTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    pdm_modulator_if.slave  bus
);
    localparam int L = INPUT_WIDTH - OUTPUT_WIDTH;

    generate
        if (OUTPUT_WIDTH < 1 || OUTPUT_WIDTH >= INPUT_WIDTH) begin : g_bad_widths
            $error("pdm_modulator: need 1 <= OUTPUT_WIDTH < INPUT_WIDTH");
        end
    endgenerate

    logic [INPUT_WIDTH:0]    sum;
    logic [OUTPUT_WIDTH-1:0] dac_d, dac_q;
    logic [L-1:0]            err_d, err_q;

    // One spare bit so sample + residue never wraps; that bit flags saturation.
    always_comb begin
        sum   = {1'b0, bus.sample} + {{(OUTPUT_WIDTH + 1){1'b0}}, err_q};
        dac_d = sum[INPUT_WIDTH-1:L];
        err_d = sum[L-1:0];
        if (sum[INPUT_WIDTH]) begin
            dac_d = '1;
            err_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dac_q <= '0;
            err_q <= '0;
        end else begin
            dac_q <= dac_d;
            err_q <= err_d;
        end
    end

    assign bus.dac_out = dac_q;
    assign bus.err_dbg = err_q;
endmodule

// File: tb/tb_pdm_modulator.sv
// Self-checking bench for pdm_modulator (INPUT_WIDTH=5, OUTPUT_WIDTH=2).
module tb_pdm_modulator;
    logic clk;
    logic reset;

    pdm_modulator_if #(.INPUT_WIDTH(5), .OUTPUT_WIDTH(2)) bus ();

    pdm_modulator #(.INPUT_WIDTH(5), .OUTPUT_WIDTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: {err[2:0], dac[1:0]} expected after each edge
    logic [4:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         m_err    = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Drive one edge of stimulus, predict, then compare after the edge.
    task automatic step(input logic rst_n, input int smp);
        int s;
        int e_dac;
        logic [4:0] got;
        logic [4:0] want;
        @(negedge clk);
        reset      = rst_n;
        bus.sample = smp[4:0];
        if (!rst_n) begin
            e_dac = 0;
            m_err = 0;
        end else begin
            s = smp + m_err;
            if (s >= 32) begin
                e_dac = 3;
                m_err = 7;
            end else begin
                e_dac = s / 8;
                m_err = s % 8;
            end
        end
        exp_q.push_back({m_err[2:0], e_dac[1:0]});
        @(posedge clk);
        #1;
        got  = {bus.err_dbg, bus.dac_out};
        want = exp_q.pop_front();
        check_val("sb_dac", int'(got[1:0]), int'(want[1:0]));
        check_val("sb_err", int'(got[4:2]), int'(want[4:2]));
    endtask

    int mid_tbl[8] = '{1, 2, 2, 2, 2, 2, 2, 2};

    initial begin
        reset      = 1'b0;
        bus.sample = '0;

        // Reset with sample=1 for two edges
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1);
            check_val("rst_dac", int'(bus.dac_out), 0);
            check_val("rst_err", int'(bus.err_dbg), 0);
        end

        // Small level: 01 only on every 8th edge
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1);
            check_val("small_dac", int'(bus.dac_out), (i % 8 == 7) ? 1 : 0);
        end

        // Mid level from err=0
        step(1'b0, 0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 15);
            check_val("mid_dac", int'(bus.dac_out), mid_tbl[i % 8]);
        end

        // Full scale saturates without wrapping
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 31);
            check_val("full_dac", int'(bus.dac_out), 3);
            check_val("full_err", int'(bus.err_dbg), 7);
        end

        // Zero level holds a residue of 5
        step(1'b0, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 1);
        check_val("pre_zero_err", int'(bus.err_dbg), 5);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 0);
            check_val("zero_dac", int'(bus.dac_out), 0);
            check_val("zero_err", int'(bus.err_dbg), 5);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1);
            check_val("resume_dac", int'(bus.dac_out), (i == 2) ? 1 : 0);
        end

        // Reset mid-operation discards the residue
        for (int i = 0; i < 3; i++) step(1'b1, 1);
        check_val("mid_rst_pre_err", int'(bus.err_dbg), 3);
        step(1'b0, 1);
        check_val("mid_rst_dac", int'(bus.dac_out), 0);
        check_val("mid_rst_err", int'(bus.err_dbg), 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1);
            check_val("restart_dac", int'(bus.dac_out), (i == 7) ? 1 : 0);
        end

        // Random levels with occasional resets, scoreboard only
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) != 0), int'($urandom_range(0, 31)));
        end

        check_val("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
